stream_downsize: RTL and testbench

Converts a wide stream beat of T_DATA_RATIO lanes back into a narrow stream of one T_DATA_WIDTH word per transfer. This is the inverse of the upsizer. It accepts one wide beat (lanes, per-lane keep, last) into a single holding register, then emits only the kept lanes, lowest lane index first. m_last_o is asserted on the final kept word of a beat whose last flag is set. The block sits at the receive side of the wide datapath, restoring the original narrow packet stream.

---
 rtl/stream_pkg.sv | 17 +
 rtl/lane_select.sv | 29 ++
 rtl/stream_downsize.sv | 81 ++++++++
 tb/tb_stream_downsize.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for stream width converters.
//   lane_idx_w          : bits needed to index a lane (at least 1)
//   onehot_count_is_one : true when exactly one bit of a lane mask is set
package stream_pkg;

  localparam int unsigned MAX_LANES = 32;

  function automatic int unsigned lane_idx_w(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic onehot_count_is_one(input logic [MAX_LANES-1:0] mask);
    return (mask != '0) && ((mask & (mask - MAX_LANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/lane_select.sv
// Priority encoder over a lane mask; lowest set lane wins.
//   i_mask     : lanes still pending
//   o_idx_c    : index of the lowest set lane (0 when mask is empty)
//   o_final_c  : exactly one lane pending
//   o_any_c    : at least one lane pending
module lane_select
  import stream_pkg::*;
#(
  parameter int unsigned RATIO = 2,
  parameter int unsigned IDX_W = lane_idx_w(RATIO)
) (
  input  logic [RATIO-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_final_c,
  output logic             o_any_c
);

  // Scan high to low so the lowest set lane is written last.
  always_comb begin
    o_idx_c = '0;
    for (int i = int'(RATIO) - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx_c = IDX_W'(i);
    end
  end

  assign o_final_c = onehot_count_is_one(MAX_LANES'(i_mask));
  assign o_any_c   = |i_mask;

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: holds one wide beat and emits its kept
// lanes one per transfer, lowest lane first.
//   clk, rst_n            : clock, async active-low reset
//   s_data_i/keep/last    : wide beat payload (lane 0 = first word)
//   s_valid_i, s_ready_o  : wide beat handshake
//   m_data_o, m_last_o    : narrow word and end-of-packet flag
//   m_valid_o, m_ready_i  : narrow word handshake
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 1,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IDX_W = lane_idx_w(T_DATA_RATIO);

  logic                    r_buf_valid;
  logic [T_DATA_WIDTH-1:0] r_buf_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] r_buf_rem;
  logic                    r_buf_last;

  logic [IDX_W-1:0]        w_cur;
  logic                    w_final;
  logic                    w_any;
  logic                    w_load;
  logic                    w_out_hs;

  lane_select #(
    .RATIO (T_DATA_RATIO),
    .IDX_W (IDX_W)
  ) u_lane_select (
    .i_mask    (r_buf_rem),
    .o_idx_c   (w_cur),
    .o_final_c (w_final),
    .o_any_c   (w_any)
  );

  // Outputs come straight from the holding buffer.
  assign m_valid_o = r_buf_valid;
  assign m_data_o  = r_buf_valid ? r_buf_data[w_cur] : '0;
  assign m_last_o  = r_buf_valid & w_final & r_buf_last;

  // Accept a new beat as the final word leaves, so beats run back-to-back.
  assign w_out_hs  = r_buf_valid & w_any & m_ready_i;
  assign s_ready_o = !r_buf_valid | (w_out_hs & w_final);
  assign w_load    = s_valid_i & s_ready_o;

  // Control state; a load overrides the final-word clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_rem   <= '0;
      r_buf_last  <= 1'b0;
    end else if (w_load) begin
      r_buf_valid <= |s_keep_i;
      r_buf_rem   <= s_keep_i;
      r_buf_last  <= s_last_i;
    end else if (w_out_hs) begin
      r_buf_rem   <= r_buf_rem & ~(T_DATA_RATIO'(1) << w_cur);
      if (w_final) r_buf_valid <= 1'b0;
    end
  end

  // Lane payload needs no reset; it is masked until the buffer is valid.
  always_ff @(posedge clk) begin
    if (w_load) r_buf_data <= s_data_i;
  end

endmodule

// File: tb/tb_stream_downsize.sv
module tb_stream_downsize;

  localparam int unsigned W = 8;
  localparam int unsigned R = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_data [R];
  logic [R-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  logic rdy_rand;
  logic rdy_dir;
  logic rdy_bit;

  int checks;
  int errors;
  int out_cnt;
  int cyc;

  logic [8:0] sb[$];

  assign m_ready = rdy_rand ? rdy_bit : rdy_dir;

  stream_downsize #(
    .T_DATA_WIDTH (W),
    .T_DATA_RATIO (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    rdy_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_bit = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: kept lanes in ascending order; last flag on the final kept one.
  function automatic void model_push(input logic [31:0] d, input logic [R-1:0] k, input logic l);
    logic [7:0] words[$];
    words = {};
    for (int i = 0; i < int'(R); i++) begin
      if (k[i]) words.push_back(d[8*i +: 8]);
    end
    for (int j = 0; j < words.size(); j++) begin
      sb.push_back({words[j], l && (j == words.size() - 1)});
    end
  endfunction

  // Offers one wide beat; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [R-1:0] k, input logic l, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < int'(R); i++) s_data[i] = d[8*i +: 8];
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end else begin
      if (k == '0) $display("warning: keep==0 beat offered (dropped by design)");
      model_push(d, k, l);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(posedge clk);
      if (out_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    #1;
  endtask

  // Monitor: pops the scoreboard on every narrow handshake, checks hold under stall.
  initial begin
    logic       stall;
    logic [7:0] pd;
    logic       pl;
    logic [8:0] exp;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(pd));
        chk("hold_last", 32'(m_last), 32'(pl));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_word", 32'(sb.size()), 32'd1);
        end else begin
          exp = sb.pop_front();
          chk("word_data", 32'(m_data), 32'(exp[8:1]));
          chk("word_last", 32'(m_last), 32'(exp[0]));
        end
        out_cnt++;
      end
      stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
    end
  end

  initial begin
    int acc_a;
    int acc_b;
    int base;
    int nrdy;
    logic [R-1:0] k;

    checks = 0;
    errors = 0;
    out_cnt = 0;
    rdy_rand = 1'b0;
    rdy_dir = 1'b1;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_keep = '0;
    s_last = 1'b0;
    for (int i = 0; i < int'(R); i++) s_data[i] = '0;

    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full beat: four words on consecutive cycles, s_ready low for three.
    base = out_cnt;
    nrdy = 0;
    send(32'h44332211, 4'b1111, 1'b1, acc_a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!s_ready) nrdy++;
    end
    @(posedge clk);
    #1;
    chk("full_out_count", 32'(out_cnt - base), 32'd4);
    chk("full_idle_after", 32'(m_valid), 32'd0);
    chk("full_sready_low", 32'(nrdy), 32'd3);

    // Sparse keep: lanes 1 and 3 back-to-back.
    base = out_cnt;
    send(32'hDDCCBBAA, 4'b1010, 1'b1, acc_a);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("sparse_out_count", 32'(out_cnt - base), 32'd2);
    chk("sparse_idle_after", 32'(m_valid), 32'd0);

    // Back-to-back beats with s_valid held between them.
    base = out_cnt;
    send(32'h04030201, 4'b0011, 1'b0, acc_a);
    send(32'h14131211, 4'b1111, 1'b1, acc_b);
    chk("b2b_accept_gap", 32'(acc_b - acc_a), 32'd2);
    for (int i = 0; i < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("b2b_out_count", 32'(out_cnt - base), 32'd6);

    // Backpressure pattern 1,0,0,1 across a full beat.
    base = out_cnt;
    send(32'h88776655, 4'b1111, 1'b0, acc_a);
    rdy_dir = 1'b1;
    @(posedge clk); #1; rdy_dir = 1'b0;
    @(posedge clk); #1; rdy_dir = 1'b0;
    @(posedge clk); #1; rdy_dir = 1'b1;
    wait_outs(base + 4, 20);

    // Empty-keep beat dropped, then a single-lane beat.
    base = out_cnt;
    send(32'hEEEEEEEE, 4'b0000, 1'b1, acc_a);
    chk("keep0_no_output", 32'(m_valid), 32'd0);
    send(32'h0000005A, 4'b0001, 1'b0, acc_a);
    wait_outs(base + 1, 20);
    @(posedge clk);
    #1;
    chk("keep0_total_out", 32'(out_cnt - base), 32'd1);

    // Asynchronous reset after two of four words.
    base = out_cnt;
    send(32'hA4A3A2A1, 4'b1111, 1'b1, acc_a);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_m_last", 32'(m_last), 32'd0);
    chk("midrst_words_before", 32'(out_cnt - base), 32'd2);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(m_valid), 32'd0);
    base = out_cnt;
    send(32'hB4B3B2B1, 4'b1111, 1'b0, acc_a);
    wait_outs(base + 4, 20);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    // Randomized beats with random downstream stalls.
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      k = R'($urandom_range(1, 15));
      if ($urandom_range(0, 19) == 0) k = '0;
      send($urandom, k, 1'($urandom_range(0, 1)), acc_a);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("random_sb_empty", 32'(sb.size()), 32'd0);
    rdy_rand = 1'b0;
    rdy_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", 32'(m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
